// File: rtl/cache_types.sv
// Shared types for the cache lookup/miss controller.
// FSM states, line metadata bundle and way index/one-hot helpers.
package cache_types;

    localparam int TAG_W = 23;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_WRITEBACK,
        ST_REFILL,
        ST_DONE
    } ctrl_state_t;

    typedef struct packed {
        logic             valid;
        logic             dirty;
        logic [TAG_W-1:0] tag;
    } line_meta_t;

    function automatic int unsigned oh2idx(input logic [31:0] oh);
        int unsigned idx;
        idx = 0;
        for (int i = 0; i < 32; i++) begin
            if (oh[i]) idx = i;
        end
        return idx;
    endfunction

    function automatic logic [31:0] idx2oh(input int unsigned idx);
        return 32'd1 << idx;
    endfunction

endpackage

// File: rtl/victim_select.sv
// Victim choice for a miss: lowest invalid way first,
// otherwise the replacement unit's eviction candidate.
module victim_select
    import cache_types::*;
#(
    parameter int WAYS = 4
) (
    input  logic [WAYS-1:0] i_valid,
    input  logic [WAYS-1:0] i_dirty,
    input  logic [WAYS-1:0] i_evict_candidate,
    output logic [WAYS-1:0] o_victim,
    output logic            o_victim_dirty
);

    logic [WAYS-1:0] w_free;
    int unsigned     w_idx;

    assign w_free = ~i_valid;

    // Scan downward so the lowest free way wins.
    always_comb begin
        w_idx = 0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (w_free[i]) w_idx = i;
        end
    end

    // Only a valid victim can carry dirty data.
    always_comb begin
        o_victim = i_evict_candidate;
        if (|w_free) o_victim = WAYS'(idx2oh(w_idx));
        o_victim_dirty = |(o_victim & i_valid & i_dirty);
    end

endmodule

// File: rtl/cache_miss_ctrl.sv
// Set-associative lookup/miss controller: owns tag/valid/dirty,
// sequences writeback and refill, drives the replacement unit.
module cache_miss_ctrl
    import cache_types::*;
#(
    parameter  int WAYS       = 4,
    parameter  int SETS       = 16,
    parameter  int TAG_WIDTH  = 23,
    localparam int ADDR_WIDTH = $clog2(SETS),
    localparam int WAYS_IDX   = $clog2(WAYS)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [ADDR_WIDTH-1:0]         req_set,
    input  logic [TAG_WIDTH-1:0]          req_tag,
    input  logic                          req_write,
    output logic                          resp_valid,
    output logic                          resp_hit,
    output logic [WAYS-1:0]               resp_way,
    output logic [ADDR_WIDTH-1:0]         plru_set,
    output logic [WAYS-1:0]               plru_hit_vector,
    output logic                          plru_update_n,
    input  logic [WAYS-1:0]               evict_candidate,
    output logic                          mem_req,
    output logic                          mem_write,
    output logic [TAG_WIDTH+ADDR_WIDTH-1:0] mem_addr,
    input  logic                          mem_ack
);

    ctrl_state_t            r_state;
    logic [ADDR_WIDTH-1:0]  r_set;
    logic [TAG_WIDTH-1:0]   r_tag;
    logic                   r_wr;
    logic                   r_hit;
    logic [WAYS-1:0]        r_way;

    logic [WAYS-1:0]        r_valid [SETS];
    logic [WAYS-1:0]        r_dirty [SETS];
    logic [TAG_WIDTH-1:0]   r_tags  [SETS][WAYS];

    logic [WAYS-1:0]        w_hit_vec;
    logic [WAYS-1:0]        w_victim;
    logic                   w_victim_dirty;
    logic [WAYS_IDX-1:0]    w_way_idx;
    line_meta_t             w_fill;

    // Tag compare across all ways of the registered set.
    always_comb begin
        w_hit_vec = '0;
        for (int w = 0; w < WAYS; w++) begin
            w_hit_vec[w] = r_valid[r_set][w]
                         && (r_tags[r_set][w] == r_tag);
        end
    end

    victim_select #(
        .WAYS (WAYS)
    ) u_victim (
        .i_valid           (r_valid[r_set]),
        .i_dirty           (r_dirty[r_set]),
        .i_evict_candidate (evict_candidate),
        .o_victim          (w_victim),
        .o_victim_dirty    (w_victim_dirty)
    );

    assign w_way_idx    = WAYS_IDX'(oh2idx(32'(r_way)));
    assign w_fill.valid = 1'b1;
    assign w_fill.dirty = 1'b0;
    assign w_fill.tag   = r_tag;

    // Outputs decode from state and registered request fields,
    // so memory signals stay stable while waiting for ack.
    assign req_ready       = (r_state == ST_IDLE);
    assign resp_valid      = (r_state == ST_DONE);
    assign resp_hit        = resp_valid & r_hit;
    assign resp_way        = resp_valid ? r_way : '0;
    assign plru_set        = r_set;
    assign plru_hit_vector = resp_way;
    assign plru_update_n   = ~resp_valid;
    assign mem_req         = (r_state == ST_WRITEBACK)
                           | (r_state == ST_REFILL);
    assign mem_write       = (r_state == ST_WRITEBACK);
    assign mem_addr        = mem_write
                           ? {r_tags[r_set][w_way_idx], r_set}
                           : {r_tag, r_set};

    // Control FSM and registered request/response fields.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_set   <= '0;
            r_tag   <= '0;
            r_wr    <= 1'b0;
            r_hit   <= 1'b0;
            r_way   <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_set   <= req_set;
                        r_tag   <= req_tag;
                        r_wr    <= req_write;
                        r_state <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    if (|w_hit_vec) begin
                        r_hit   <= 1'b1;
                        r_way   <= w_hit_vec;
                        r_state <= ST_DONE;
                    end else begin
                        r_hit   <= 1'b0;
                        r_way   <= w_victim;
                        r_state <= w_victim_dirty ? ST_WRITEBACK
                                                  : ST_REFILL;
                    end
                end
                ST_WRITEBACK: begin
                    if (mem_ack) r_state <= ST_REFILL;
                end
                ST_REFILL: begin
                    if (mem_ack) r_state <= ST_DONE;
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Valid/dirty bits: cleared by reset, updated on acks and stores.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++) begin
                r_valid[s] <= '0;
                r_dirty[s] <= '0;
            end
        end else begin
            unique case (r_state)
                ST_WRITEBACK: begin
                    if (mem_ack) r_dirty[r_set][w_way_idx] <= 1'b0;
                end
                ST_REFILL: begin
                    if (mem_ack) begin
                        r_valid[r_set][w_way_idx] <= w_fill.valid;
                        r_dirty[r_set][w_way_idx] <= w_fill.dirty;
                    end
                end
                ST_DONE: begin
                    if (r_wr) r_dirty[r_set][w_way_idx] <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // Tag storage needs no reset; valid gates every use.
    always_ff @(posedge clk) begin
        if ((r_state == ST_REFILL) && mem_ack) begin
            r_tags[r_set][w_way_idx] <= w_fill.tag;
        end
    end

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// Bench for cache_miss_ctrl: directed scenarios plus random traffic
// against an array-based cache model with bench-driven victims.
module tb_cache_miss_ctrl;

    localparam int WAYS = 4;
    localparam int SETS = 16;
    localparam int TW   = 23;
    localparam int AW   = 4;

    logic            clk;
    logic            rst_n;
    logic            req_valid;
    logic            req_ready;
    logic [AW-1:0]   req_set;
    logic [TW-1:0]   req_tag;
    logic            req_write;
    logic            resp_valid;
    logic            resp_hit;
    logic [WAYS-1:0] resp_way;
    logic [AW-1:0]   plru_set;
    logic [WAYS-1:0] plru_hit_vector;
    logic            plru_update_n;
    logic [WAYS-1:0] evict_candidate;
    logic            mem_req;
    logic            mem_write;
    logic [TW+AW-1:0] mem_addr;
    logic            mem_ack;

    int checks;
    int errors;

    bit           m_valid [SETS][WAYS];
    bit           m_dirty [SETS][WAYS];
    logic [TW-1:0] m_tag  [SETS][WAYS];

    cache_miss_ctrl #(
        .WAYS      (WAYS),
        .SETS      (SETS),
        .TAG_WIDTH (TW)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_set         (req_set),
        .req_tag         (req_tag),
        .req_write       (req_write),
        .resp_valid      (resp_valid),
        .resp_hit        (resp_hit),
        .resp_way        (resp_way),
        .plru_set        (plru_set),
        .plru_hit_vector (plru_hit_vector),
        .plru_update_n   (plru_update_n),
        .evict_candidate (evict_candidate),
        .mem_req         (mem_req),
        .mem_write       (mem_write),
        .mem_addr        (mem_addr),
        .mem_ack         (mem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < WAYS; w++) begin
                m_valid[s][w] = 1'b0;
                m_dirty[s][w] = 1'b0;
                m_tag[s][w]   = '0;
            end
        end
    endtask

    // One access from IDLE through DONE; returns at posedge+1 in IDLE.
    task automatic run_access(input int set, input logic [TW-1:0] tag,
                              input bit wr, input int cand,
                              input int wb_wait, input int rf_wait,
                              input bit hold, input bit spur);
        int hit_way;
        int nm;
        int victim;
        bit exp_hit;
        logic [WAYS-1:0] exp_way;
        logic [AW-1:0] s4;
        int nph;
        bit ph_wr [2];
        logic [TW+AW-1:0] ph_addr [2];
        int ph_wait [2];
        int p;
        int n;
        int cyc;
        int exp_done;
        bit done;
        bit acked;
        s4 = set[AW-1:0];
        hit_way = -1;
        nm = 0;
        nph = 0;
        p = 0;
        n = 0;
        done = 0;
        for (int w = 0; w < WAYS; w++) begin
            if (m_valid[set][w] && m_tag[set][w] == tag) begin
                nm++;
                hit_way = w;
            end
        end
        if (nm > 1) begin
            errors++;
            $display("FAIL multi_match: set %0d has %0d matches, required 1", set, nm);
        end
        if (hit_way >= 0) begin
            exp_hit = 1;
            exp_way = WAYS'(1 << hit_way);
        end else begin
            exp_hit = 0;
            victim = -1;
            for (int w = WAYS - 1; w >= 0; w--) begin
                if (!m_valid[set][w]) victim = w;
            end
            if (victim < 0) victim = cand;
            exp_way = WAYS'(1 << victim);
            if (m_valid[set][victim] && m_dirty[set][victim]) begin
                ph_wr[0]   = 1;
                ph_addr[0] = {m_tag[set][victim], s4};
                ph_wait[0] = wb_wait;
                nph = 1;
            end
            ph_wr[nph]   = 0;
            ph_addr[nph] = {tag, s4};
            ph_wait[nph] = rf_wait;
            nph++;
        end
        exp_done = 2;
        for (int k = 0; k < nph; k++) exp_done += ph_wait[k] + 1;

        req_valid       = 1'b1;
        req_set         = s4;
        req_tag         = tag;
        req_write       = wr;
        evict_candidate = WAYS'(1 << cand);
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_ready: got %b, required 1", req_ready);
        end
        @(posedge clk);
        #1;
        if (!hold) req_valid = 1'b0;
        if (spur) mem_ack = 1'b1;
        cyc = 1;
        while (!done && cyc < 200) begin
            acked = 0;
            @(negedge clk);
            if (resp_valid === 1'b1) begin
                done = 1;
                checks++;
                if (cyc != exp_done) begin
                    errors++;
                    $display("FAIL resp_latency: got %0d, required %0d", cyc, exp_done);
                end
                checks++;
                if (resp_hit !== exp_hit) begin
                    errors++;
                    $display("FAIL resp_hit: got %b, required %b", resp_hit, exp_hit);
                end
                checks++;
                if (resp_way !== exp_way) begin
                    errors++;
                    $display("FAIL resp_way: got %b, required %b", resp_way, exp_way);
                end
                checks++;
                if (plru_update_n !== 1'b0 || plru_hit_vector !== exp_way
                    || plru_set !== s4) begin
                    errors++;
                    $display("FAIL plru_update: got n=%b hv=%b set=%0d, required n=0 hv=%b set=%0d",
                             plru_update_n, plru_hit_vector, plru_set, exp_way, s4);
                end
                checks++;
                if (mem_req !== 1'b0 || p != nph || req_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL done_state: got mem_req=%b phases=%0d ready=%b, required 0 %0d 0",
                             mem_req, p, req_ready, nph);
                end
                if (spur) mem_ack = 1'b1;
            end else begin
                checks++;
                if (plru_update_n !== 1'b1 || req_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL busy_outputs: got upd_n=%b ready=%b, required 1 0",
                             plru_update_n, req_ready);
                end
                if (mem_req === 1'b1) begin
                    checks++;
                    if (p >= nph || cyc < 2) begin
                        errors++;
                        $display("FAIL unexpected_mem: got mem_req=1 at cycle %0d, required 0", cyc);
                    end else if (mem_write !== ph_wr[p] || mem_addr !== ph_addr[p]) begin
                        errors++;
                        $display("FAIL mem_cmd: got wr=%b addr=%h, required wr=%b addr=%h",
                                 mem_write, mem_addr, ph_wr[p], ph_addr[p]);
                    end else begin
                        n++;
                        if (n == ph_wait[p] + 1) begin
                            mem_ack = 1'b1;
                            acked = 1;
                        end
                    end
                end else if (cyc >= 2) begin
                    checks++;
                    errors++;
                    $display("FAIL missing_mem: got mem_req=%b at cycle %0d, required 1", mem_req, cyc);
                end
            end
            @(posedge clk);
            #1;
            mem_ack = 1'b0;
            if (acked) begin
                p++;
                n = 0;
            end
            cyc++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL resp_timeout: got no resp_valid in %0d cycles, required one", cyc);
        end
        if (exp_hit) begin
            if (wr) m_dirty[set][hit_way] = 1'b1;
        end else begin
            m_valid[set][victim] = 1'b1;
            m_tag[set][victim]   = tag;
            m_dirty[set][victim] = wr;
        end
    endtask

    task automatic test_reset();
        rst_n           = 1'b0;
        req_valid       = 1'b0;
        req_set         = '0;
        req_tag         = '0;
        req_write       = 1'b0;
        evict_candidate = 4'b0001;
        mem_ack         = 1'b0;
        model_reset();
        #1;
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got ready=%b resp=%b mem_req=%b, required 1 0 0",
                     req_ready, resp_valid, mem_req);
        end
        checks++;
        if (plru_update_n !== 1'b1 || plru_hit_vector !== 4'b0000
            || plru_set !== 4'd0) begin
            errors++;
            $display("FAIL reset_plru: got n=%b hv=%b set=%0d, required 1 0000 0",
                     plru_update_n, plru_hit_vector, plru_set);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_cold_miss();
        run_access(3, 23'h12, 0, 0, 0, 4, 0, 0);
    endtask

    task automatic test_hit();
        run_access(3, 23'h12, 0, 2, 0, 0, 0, 1);
    endtask

    task automatic test_fill_evict();
        for (int t = 1; t <= 4; t++) run_access(5, TW'(t), 0, 3, 0, 1, 0, 0);
        run_access(5, 23'h9, 0, 2, 0, 0, 0, 0);
        run_access(5, 23'h9, 0, 1, 0, 0, 0, 0);
    endtask

    task automatic test_dirty_evict();
        run_access(5, 23'h9, 1, 0, 0, 0, 0, 0);
        run_access(5, 23'hA, 0, 2, 2, 1, 0, 0);
        run_access(5, 23'hA, 0, 0, 0, 0, 0, 0);
        run_access(5, 23'hB, 0, 2, 0, 0, 0, 0);
    endtask

    task automatic test_reset_mid_refill();
        bit seen;
        seen = 0;
        req_valid       = 1'b1;
        req_set         = 4'd7;
        req_tag         = 23'h33;
        req_write       = 1'b0;
        evict_candidate = 4'b0001;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (mem_req === 1'b1) seen = 1;
        end
        checks++;
        if (!seen || mem_write !== 1'b0) begin
            errors++;
            $display("FAIL refill_start: got mem_req=%b wr=%b, required 1 0", seen, mem_write);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_abort: got mem_req=%b resp=%b ready=%b, required 0 0 1",
                     mem_req, resp_valid, req_ready);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (resp_valid !== 1'b0 || mem_req !== 1'b0) begin
                errors++;
                $display("FAIL post_reset_idle: got resp=%b mem_req=%b, required 0 0",
                         resp_valid, mem_req);
            end
        end
        @(posedge clk);
        #1;
        run_access(7, 23'h33, 0, 0, 0, 0, 0, 0);
        run_access(3, 23'h12, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_back_to_back();
        run_access(9, 23'h40, 1, 0, 0, 2, 1, 0);
        run_access(9, 23'h40, 0, 0, 0, 0, 1, 0);
        run_access(9, 23'h41, 0, 0, 0, 1, 1, 0);
        run_access(9, 23'h40, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 120; i++) begin
            run_access($urandom_range(0, 2), TW'($urandom_range(0, 6)),
                       1'($urandom_range(0, 1)), $urandom_range(0, 3),
                       $urandom_range(0, 3), $urandom_range(0, 3),
                       1'($urandom_range(0, 1)) && (i != 119),
                       1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_cold_miss();
        test_hit();
        test_fill_evict();
        test_dirty_evict();
        test_reset_mid_refill();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cache_miss_ctrl.md
Name: cache_miss_ctrl

Overview:
Set-associative cache lookup/miss controller that owns the tag, valid and dirty arrays. It drives the replacement unit's access side: set address, one-hot hit vector and update strobe. It consumes the unit's one-hot eviction candidate on a miss, sequences a dirty-victim writeback and a line refill over a simple memory handshake, installs the new tag, and reports the serviced way back to the pipeline.

Parameters:
WAYS, 4, associativity (power of two, >= 2)
SETS, 16, number of sets (power of two)
TAG_WIDTH, 23, tag bits per line
ADDR_WIDTH (local), $clog2(SETS), set index width
WAYS_IDX (local), $clog2(WAYS), way index width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  pipeline lookup request
req_ready  out  1  controller can accept a request
req_set  in  ADDR_WIDTH  set index
req_tag  in  TAG_WIDTH  tag
req_write  in  1  store access; marks the line dirty
resp_valid  out  1  one-cycle pulse: access serviced
resp_hit  out  1  access was a hit
resp_way  out  WAYS  one-hot serviced way
plru_set  out  ADDR_WIDTH  set address to the replacement unit
plru_hit_vector  out  WAYS  one-hot way just accessed
plru_update_n  out  1  active-low replacement-state write strobe
evict_candidate  in  WAYS  one-hot victim from the replacement unit
mem_req  out  1  memory transaction request, held until mem_ack
mem_write  out  1  1 = writeback, 0 = refill read
mem_addr  out  TAG_WIDTH+ADDR_WIDTH  line address {tag, set}
mem_ack  in  1  one-cycle completion from memory

Behaviour:
- Reset (async, rst_n = 0):
  - State = IDLE; all valid and dirty bits = 0; tags are don't-care.
  - req_ready = 1, resp_valid = 0, mem_req = 0, plru_update_n = 1, plru_hit_vector = 0, plru_set = 0.
  - Reset mid-transaction aborts it with no response; the next request is treated as a cold miss.
- States: IDLE, LOOKUP, WRITEBACK, REFILL, DONE.
- IDLE:
  - req_ready = 1.
  - On req_valid, register set/tag/write and go to LOOKUP.
  - req_ready = 0 in every other state.
- LOOKUP (1 cycle):
  - plru_set = registered set.
  - hit_vector[w] = valid[set][w] & (tag[set][w] == req tag).
  - Hit -> DONE.
  - Miss -> choose victim: the lowest-index invalid way if any exists, else evict_candidate sampled this cycle.
  - Victim valid & dirty -> WRITEBACK; otherwise -> REFILL.
  - Victim one-hot is registered.
- WRITEBACK:
  - mem_req = 1, mem_write = 1, mem_addr = {victim tag, set}.
  - On mem_ack -> REFILL; clear the victim's dirty bit.
- REFILL:
  - mem_req = 1, mem_write = 0, mem_addr = {req tag, set}.
  - On mem_ack: write tag, valid = 1, dirty = 0; -> DONE.
- DONE (1 cycle):
  - resp_valid = 1; resp_hit = hit flag; resp_way = hit vector or victim.
  - plru_update_n = 0 with plru_hit_vector = resp_way and plru_set = set.
  - If req_write, set dirty[set][way].
  - -> IDLE.
- Outputs are registered or decoded from state only; mem_req/mem_write/mem_addr are stable while waiting.
- Latency:
  - Hit: accept in cycle 0, resp_valid in cycle 2.
  - Clean miss: 2 cycles + refill ack wait + 1.
  - Dirty miss: adds the writeback wait.
- mem_ack outside WRITEBACK/REFILL is ignored. An ack in the same cycle mem_req first rises is legal.
- Multiple tag matches in one set is illegal; a bench assertion flags it.
- A non-one-hot evict_candidate with all ways valid is illegal; asserted.
- Write hit: dirty set in DONE; no memory traffic.

Decomposition:
- cache_types package: ctrl state enum (IDLE, LOOKUP, WRITEBACK, REFILL, DONE), a line-metadata struct {valid, dirty, tag}, and a shared way-index/one-hot conversion function.
- One sub-module, victim_select: combinational; inputs are the valid and dirty vectors plus evict_candidate; outputs are victim one-hot and victim_dirty; implements the invalid-first priority.
- Metadata storage uses flop arrays with asynchronous active-low clear of valid/dirty.

Test Plan:
- Cold miss, set 3, tag 0x12, read, after reset -> no writeback, one REFILL with mem_addr = {0x12,3}; ack after 5 cycles -> resp_valid, resp_hit = 0, resp_way = 0001, plru_update_n low one cycle with hit vector 0001.
- Re-access set 3, tag 0x12 -> resp_valid at cycle 2, resp_hit = 1, resp_way = 0001, no mem_req.
- Fill set 5 with tags 1..4, then miss tag 9 with evict_candidate = 0100 and way 2 clean -> victim 0100, refill only, tag[5][2] = 9.
- Store hit on set 5 way 2, then miss tag 0xA with candidate 0100 -> WRITEBACK mem_write = 1, mem_addr = {9,5}, then REFILL {0xA,5}, new line clean.
- Assert rst_n low during the REFILL wait -> mem_req drops immediately, no resp_valid; the next access to that set misses.
- req_valid held continuously during a miss -> req_ready = 0 until after DONE; second request accepted in IDLE the cycle after resp_valid.
